uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver. Consumer of the uart_tx serial line: recovers

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// UART receiver signal bundle.
// The line and config come from the transmitter side; the word and flags go back.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver with 3-sample majority vote.
// Start, LSB-first data, optional parity and one stop bit.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] C_HM1  = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] C_H    = CW'(PRESCALE/2);
  localparam logic [CW-1:0] C_HP1  = CW'(PRESCALE/2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_rx_s;
  logic                  r_smp0;
  logic                  r_smp1;
  logic [CW-1:0]         r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic w_bit_val;
  logic w_smp_pt;
  logic w_wrap;

  assign w_bit_val = (r_smp0 & r_smp1) |
                     (r_smp0 & r_rx_s) |
                     (r_smp1 & r_rx_s);
  assign w_smp_pt  = (r_edge_cnt == C_HP1);
  assign w_wrap    = (r_edge_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_rx_s     <= 1'b1;
      r_smp0     <= 1'b1;
      r_smp1     <= 1'b1;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_bad  <= 1'b0;
      r_pdata    <= '0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else begin
      r_sync1   <= bus.RX_IN;
      r_rx_s    <= r_sync1;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;

      if (r_edge_cnt == C_HM1) r_smp0 <= r_rx_s;
      if (r_edge_cnt == C_H)   r_smp1 <= r_rx_s;

      if (r_state != S_IDLE)
        r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + 1'b1;

      unique case (r_state)
        S_IDLE: begin
          // detect cycle is edge 0 of the start bit
          if (!r_rx_s) begin
            r_state    <= S_START;
            r_edge_cnt <= CW'(1);
            r_bit_cnt  <= '0;
            r_par_en   <= bus.PAR_EN;
            r_par_typ  <= bus.PAR_TYP;
            r_par_bad  <= 1'b0;
          end
        end
        S_START: begin
          if (w_smp_pt && w_bit_val) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_wrap) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_smp_pt)
            r_shift <= {w_bit_val, r_shift[DATA_WIDTH-1:1]};
          if (w_wrap) begin
            if (r_bit_cnt == B_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_smp_pt)
            r_par_bad <= w_bit_val ^ (^r_shift) ^ r_par_typ;
          if (w_wrap)
            r_state <= S_STOP;
        end
        S_STOP: begin
          // leave mid-stop so a gapless next start edge is seen
          if (w_smp_pt) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_stp_err  <= ~w_bit_val;
            r_par_err  <= r_par_bad;
            if (w_bit_val && !r_par_bad) begin
              r_valid <= 1'b1;
              r_pdata <= r_shift;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.P_DATA     = r_pdata;
  assign bus.DATA_VALID = r_valid;
  assign bus.PAR_ERR    = r_par_err;
  assign bus.STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx against a frame-level event model.
// Expected pulses carry their exact cycle, flags and P_DATA.
module tb_uart_rx;

  localparam int P  = 8;
  localparam int H  = P / 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(
    .DATA_WIDTH(DW),
    .PRESCALE  (P)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          c;
    logic [2:0]  f;
    logic [7:0]  d;
  } ev_t;

  ev_t obs[$];
  ev_t expq[$];

  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;
  logic [7:0] last_good;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR) begin
      e.c = cyc;
      e.f = {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR};
      e.d = bus.P_DATA;
      obs.push_back(e);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d, logic pe, logic pt,
                      logic pbad, logic stp);
    ev_t  e;
    int   n;
    logic pbit;
    logic perr;
    logic serr;
    bus.PAR_EN  = pe;
    bus.PAR_TYP = pt;
    pbit = (^d) ^ pt ^ pbad;
    n    = pe ? 11 : 10;
    perr = pe & pbad;
    serr = ~stp;
    e.c  = cyc + 2 + (n - 1) * P + H + 2;
    e.f  = {~perr & ~serr, perr, serr};
    if (e.f[2]) last_good = d;
    e.d = last_good;
    expq.push_back(e);
    bus.RX_IN = 1'b0;
    tick(4);
    bus.PAR_EN  = 1'($urandom);
    bus.PAR_TYP = 1'($urandom);
    tick(P - 4);
    for (int i = 0; i < 8; i++) begin
      bus.RX_IN = d[i];
      tick(P);
    end
    if (pe) begin
      bus.RX_IN = pbit;
      tick(P);
    end
    bus.RX_IN = stp;
    tick(P);
    bus.RX_IN = 1'b1;
    if (!stp) tick(2 * P);
  endtask

  task automatic compare(string tag);
    ev_t o;
    ev_t x;
    tick(2 * P);
    chk({tag, "_cnt"}, obs.size(), expq.size());
    while (obs.size() > 0 && expq.size() > 0) begin
      o = obs.pop_front();
      x = expq.pop_front();
      chk({tag, "_cyc"},  o.c, x.c);
      chk({tag, "_flag"}, {29'd0, o.f}, {29'd0, x.f});
      chk({tag, "_data"}, {24'd0, o.d}, {24'd0, x.d});
    end
    obs.delete();
    expq.delete();
  endtask

  initial begin
    ev_t e;
    int  k;
    int  d;
    reset       = 1'b1;
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    last_good   = 8'h00;
    tick(3);
    chk("rst_pdata", {24'd0, bus.P_DATA}, 32'd0);
    chk("rst_dv",    {31'd0, bus.DATA_VALID}, 32'd0);
    chk("rst_pe",    {31'd0, bus.PAR_ERR}, 32'd0);
    chk("rst_se",    {31'd0, bus.STP_ERR}, 32'd0);
    reset = 1'b0;
    tick(2);

    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    compare("t1");

    send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    compare("t2");

    send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    compare("t3");
    chk("t3_hold", {24'd0, bus.P_DATA}, 32'h3C);

    bus.RX_IN = 1'b0;
    tick(2);
    bus.RX_IN = 1'b1;
    tick(3 * P);
    compare("t4");
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    compare("t4b");

    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    compare("t5");

    bus.PAR_EN = 1'b0;
    bus.RX_IN  = 1'b0;
    tick(P);
    for (int i = 0; i < 3; i++) begin
      bus.RX_IN = 1'b0;
      tick(P);
    end
    bus.RX_IN = 1'b1;
    tick(H);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_pdata", {24'd0, bus.P_DATA}, 32'd0);
    chk("t6_rst_dv",    {31'd0, bus.DATA_VALID}, 32'd0);
    reset     = 1'b0;
    last_good = 8'h00;
    tick(3 * P);
    send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    compare("t6");

    bus.PAR_EN = 1'b0;
    k = cyc;
    bus.RX_IN = 1'b0;
    tick(3 * (9 * P + H + 2));
    bus.RX_IN = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      e.c = k + 2 + j * (9 * P + H + 2);
      e.f = 3'b001;
      e.d = last_good;
      expq.push_back(e);
    end
    tick(2 * P);
    compare("idle_low");
    send(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
    compare("idle_low_rec");

    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) != 0));
      d = $urandom_range(0, 2);
      if (d > 0) tick(d);
      if (i % 50 == 49) compare("rand");
    end
    compare("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
